// File: rtl/acl_poll_sched_if.sv
// rtl/acl_poll_sched_if.sv - scheduler control, response and command bundle
// master: the scheduler itself; slave: baseband/environment that drives slots and responses.
interface acl_poll_sched_if #(
  parameter int POLL_W = 16
);
  logic              regi_isMaster;
  logic              ms_tslot_p;
  logic              rx_done_p;
  logic [2:0]        dec_lt_addr;
  logic [7:0]        dec_arqn;
  logic [7:0]        dec_flow;
  logic [7:0]        regi_active_mask;
  logic [7:0]        regi_txdata_valid;
  logic [3:0]        regi_packet_type;
  logic [3:0]        regi_max_retry;
  logic [POLL_W-1:0] regi_tpoll;
  logic              sched_txcmd_p;
  logic [2:0]        sched_lt_addr;
  logic [3:0]        sched_pktype;
  logic              sched_retx;
  logic              txdata_done_p;
  logic              sched_flush_p;
  logic              sched_busy;

  modport master (
    input  regi_isMaster, ms_tslot_p, rx_done_p, dec_lt_addr, dec_arqn, dec_flow,
           regi_active_mask, regi_txdata_valid, regi_packet_type, regi_max_retry, regi_tpoll,
    output sched_txcmd_p, sched_lt_addr, sched_pktype, sched_retx,
           txdata_done_p, sched_flush_p, sched_busy
  );

  modport slave (
    output regi_isMaster, ms_tslot_p, rx_done_p, dec_lt_addr, dec_arqn, dec_flow,
           regi_active_mask, regi_txdata_valid, regi_packet_type, regi_max_retry, regi_tpoll,
    input  sched_txcmd_p, sched_lt_addr, sched_pktype, sched_retx,
           txdata_done_p, sched_flush_p, sched_busy
  );
endinterface

// File: rtl/acl_poll_sched.sv
// rtl/acl_poll_sched.sv - master ACL TX scheduler: LT_ADDR arbitration, ARQ retry/flush, poll timers
// One command per master TX slot; the response slot (or its absence) settles ARQN/FLOW.
module acl_poll_sched #(
  parameter int POLL_W = 16
) (
  input logic              clk_6M,
  input logic              rst,
  acl_poll_sched_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ISSUE, S_WAIT} state_e;
  localparam logic [3:0] PKT_POLL = 4'h1;

  state_e            state_q, state_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]        flow_go_q, flow_go_d;
  logic [3:0]        retry_cnt_q, retry_cnt_d;
  logic              retry_pend_q, retry_pend_d;
  logic [2:0]        retry_lt_q, retry_lt_d;
  logic              last_data_q, last_data_d;
  logic [POLL_W-1:0] poll_cnt_q [8];
  logic [POLL_W-1:0] poll_cnt_d [8];
  logic              txcmd_q, txcmd_d;
  logic [2:0]        lt_q, lt_d;
  logic [3:0]        pktype_q, pktype_d;
  logic              retx_q, retx_d;
  logic              done_q, done_d;
  logic              flush_q, flush_d;

  logic [7:0] active, poll_due, cand;
  logic       resp_match, timeout, nack, retry_hit, rr_hit, sel_data;
  logic [2:0] rr_sel, scan;
  logic [3:0] retry_inc;

  assign active     = bus.regi_active_mask & 8'hfe;
  assign resp_match = (state_q == S_WAIT) && bus.rx_done_p && (bus.dec_lt_addr == lt_q);
  assign timeout    = (state_q == S_WAIT) && bus.ms_tslot_p && !resp_match;
  assign nack       = timeout || !bus.dec_arqn[lt_q];
  assign retry_inc  = (retry_cnt_q == 4'hf) ? 4'hf : retry_cnt_q + 4'd1;
  assign retry_hit  = retry_pend_q && flow_go_q[retry_lt_q];
  assign sel_data   = bus.regi_txdata_valid[rr_sel] && flow_go_q[rr_sel];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      poll_due[i] = (bus.regi_tpoll != '0) && (poll_cnt_q[i] >= bus.regi_tpoll);
      cand[i]     = active[i] && ((bus.regi_txdata_valid[i] && flow_go_q[i]) || poll_due[i]);
    end
  end

  // Round-robin over LT_ADDR 1..7 starting just after the last RR pick.
  always_comb begin
    rr_hit = 1'b0;
    rr_sel = 3'd1;
    scan   = rr_ptr_q;
    for (int k = 0; k < 7; k++) begin
      scan = (scan == 3'd7) ? 3'd1 : scan + 3'd1;
      if (!rr_hit && cand[scan]) begin
        rr_hit = 1'b1;
        rr_sel = scan;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    flow_go_d    = flow_go_q;
    retry_cnt_d  = retry_cnt_q;
    retry_pend_d = retry_pend_q;
    retry_lt_d   = retry_lt_q;
    last_data_d  = last_data_q;
    poll_cnt_d   = poll_cnt_q;
    txcmd_d      = 1'b0;
    lt_d         = lt_q;
    pktype_d     = pktype_q;
    retx_d       = retx_q;
    done_d       = 1'b0;
    flush_d      = 1'b0;

    if (!bus.regi_isMaster) begin
      state_d = S_IDLE;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (!active[i]) begin
          poll_cnt_d[i] = '0;
        end else if (bus.ms_tslot_p && (poll_cnt_q[i] != '1)) begin
          poll_cnt_d[i] = poll_cnt_q[i] + POLL_W'(1);
        end
      end

      if (resp_match) begin
        flow_go_d[lt_q]  = bus.dec_flow[lt_q];
        poll_cnt_d[lt_q] = '0;
      end else if (bus.rx_done_p) begin
        flow_go_d[bus.dec_lt_addr] = bus.dec_flow[bus.dec_lt_addr];
      end

      // A missing response counts as NAK; POLL outcomes never touch retry state.
      if ((resp_match || timeout) && last_data_q) begin
        if (!nack) begin
          done_d       = 1'b1;
          retry_cnt_d  = 4'd0;
          retry_pend_d = 1'b0;
        end else if ((bus.regi_max_retry != 4'd0) && (retry_inc == bus.regi_max_retry)) begin
          done_d       = 1'b1;
          flush_d      = 1'b1;
          retry_cnt_d  = 4'd0;
          retry_pend_d = 1'b0;
        end else begin
          retry_cnt_d  = retry_inc;
          retry_pend_d = 1'b1;
        end
      end

      case (state_q)
        S_IDLE: if (bus.ms_tslot_p) state_d = S_ARB;
        S_ARB: begin
          if (retry_hit) begin
            lt_d        = retry_lt_q;
            pktype_d    = bus.regi_packet_type;
            retx_d      = 1'b1;
            last_data_d = 1'b1;
            txcmd_d     = 1'b1;
            state_d     = S_ISSUE;
          end else if (rr_hit) begin
            lt_d        = rr_sel;
            rr_ptr_d    = rr_sel;
            pktype_d    = sel_data ? bus.regi_packet_type : PKT_POLL;
            retx_d      = 1'b0;
            last_data_d = sel_data;
            txcmd_d     = 1'b1;
            state_d     = S_ISSUE;
            if (sel_data) begin
              retry_lt_d   = rr_sel;
              retry_cnt_d  = 4'd0;
              retry_pend_d = 1'b0;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (bus.ms_tslot_p) state_d = S_ARB;
          else if (resp_match) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= 3'd7;
      flow_go_q    <= 8'hff;
      retry_cnt_q  <= 4'd0;
      retry_pend_q <= 1'b0;
      retry_lt_q   <= 3'd0;
      last_data_q  <= 1'b0;
      for (int i = 0; i < 8; i++) poll_cnt_q[i] <= '0;
      txcmd_q      <= 1'b0;
      lt_q         <= 3'd0;
      pktype_q     <= 4'd0;
      retx_q       <= 1'b0;
      done_q       <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      flow_go_q    <= flow_go_d;
      retry_cnt_q  <= retry_cnt_d;
      retry_pend_q <= retry_pend_d;
      retry_lt_q   <= retry_lt_d;
      last_data_q  <= last_data_d;
      poll_cnt_q   <= poll_cnt_d;
      txcmd_q      <= txcmd_d;
      lt_q         <= lt_d;
      pktype_q     <= pktype_d;
      retx_q       <= retx_d;
      done_q       <= done_d;
      flush_q      <= flush_d;
    end
  end

  assign bus.sched_txcmd_p = txcmd_q;
  assign bus.sched_lt_addr = lt_q;
  assign bus.sched_pktype  = pktype_q;
  assign bus.sched_retx    = retx_q;
  assign bus.txdata_done_p = done_q;
  assign bus.sched_flush_p = flush_q;
  assign bus.sched_busy    = (state_q != S_IDLE);
endmodule

// File: tb/tb_acl_poll_sched.sv
// tb/tb_acl_poll_sched.sv - bench for acl_poll_sched: directed scenarios plus random slots vs a reference model
module tb_acl_poll_sched;
  logic clk_6M = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  acl_poll_sched_if #(.POLL_W(16)) bus ();
  acl_poll_sched #(.POLL_W(16)) dut (.clk_6M(clk_6M), .rst(rst), .bus(bus));

  always #5 clk_6M = ~clk_6M;

  // reference model state
  bit m_flow [8];
  int m_poll [8];
  int m_rr, m_rcnt, m_rlt, m_lt;
  bit m_pend, m_wait, m_data;
  int o_hit, o_lt, o_pt, o_retx, o_done, o_flush;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_6M);
    #1;
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin
      m_flow[i] = 1'b1;
      m_poll[i] = 0;
    end
    m_rr = 7; m_pend = 0; m_rcnt = 0; m_rlt = 0; m_wait = 0; m_lt = 0; m_data = 0;
  endfunction

  function automatic void m_resp(input bit to, input bit ack, output bit d, output bit f);
    int n;
    d = 0;
    f = 0;
    if (!m_data) return;
    if (!to && ack) begin
      d = 1; m_rcnt = 0; m_pend = 0;
    end else begin
      n = (m_rcnt < 15) ? m_rcnt + 1 : 15;
      if (bus.regi_max_retry != 0 && n == int'(bus.regi_max_retry)) begin
        d = 1; f = 1; m_rcnt = 0; m_pend = 0;
      end else begin
        m_rcnt = n; m_pend = 1;
      end
    end
  endfunction

  function automatic void m_arb(output bit hit, output int lt, output int pt, output bit rx);
    int  i;
    bit  dat, pd;
    hit = 0; lt = 0; pt = 0; rx = 0;
    if (m_pend && m_flow[m_rlt]) begin
      hit = 1; lt = m_rlt; pt = int'(bus.regi_packet_type); rx = 1; m_data = 1;
    end else begin
      for (int k = 1; k <= 7; k++) begin
        i   = (m_rr + k - 1) % 7 + 1;
        dat = bus.regi_active_mask[i] && bus.regi_txdata_valid[i] && m_flow[i];
        pd  = bus.regi_active_mask[i] && bus.regi_tpoll != 0 && m_poll[i] >= int'(bus.regi_tpoll);
        if (!hit && (dat || pd)) begin
          hit = 1; lt = i; pt = dat ? int'(bus.regi_packet_type) : 1; m_rr = i; m_data = dat;
          if (dat) begin
            m_rlt = i; m_rcnt = 0; m_pend = 0;
          end
        end
      end
    end
    if (hit) m_lt = lt;
  endfunction

  task automatic set_cfg(input logic [7:0] am, input logic [7:0] tv, input int tp, input int mr,
                         input logic [3:0] pt);
    bus.regi_active_mask  = am;
    bus.regi_txdata_valid = tv;
    bus.regi_tpoll        = 16'(tp);
    bus.regi_max_retry    = 4'(mr);
    bus.regi_packet_type  = pt;
    for (int i = 1; i < 8; i++) if (!am[i]) m_poll[i] = 0;
  endtask

  // One master TX slot; same_rx puts a matching response in the slot-start cycle.
  task automatic slot(input bit same_rx, input logic [7:0] arqn, input logic [7:0] flow);
    bit ed, ef, hit, rx;
    bit matched;
    int lt, pt;
    ed = 0; ef = 0;
    matched = m_wait && same_rx;
    if (m_wait) begin
      if (same_rx) begin
        bus.rx_done_p   = 1'b1;
        bus.dec_lt_addr = 3'(m_lt);
        bus.dec_arqn    = arqn;
        bus.dec_flow    = flow;
        m_flow[m_lt]    = flow[m_lt];
        m_resp(0, arqn[m_lt], ed, ef);
      end else begin
        m_resp(1, 0, ed, ef);
      end
    end
    bus.ms_tslot_p = 1'b1;
    for (int i = 1; i < 8; i++)
      if (bus.regi_active_mask[i] && m_poll[i] < 65535) m_poll[i]++;
    if (matched) m_poll[m_lt] = 0;
    m_wait = 0;
    tick();
    bus.ms_tslot_p = 1'b0;
    bus.rx_done_p  = 1'b0;
    o_done  = int'(bus.txdata_done_p);
    o_flush = int'(bus.sched_flush_p);
    check("resp_done", o_done, int'(ed));
    check("resp_flush", o_flush, int'(ef));
    check("arb_no_cmd", int'(bus.sched_txcmd_p), 0);
    check("arb_busy", int'(bus.sched_busy), 1);
    m_arb(hit, lt, pt, rx);
    tick();
    o_hit  = int'(bus.sched_txcmd_p);
    o_lt   = int'(bus.sched_lt_addr);
    o_pt   = int'(bus.sched_pktype);
    o_retx = int'(bus.sched_retx);
    check("txcmd", o_hit, int'(hit));
    if (hit) begin
      check("lt_addr", o_lt, lt);
      check("pktype", o_pt, pt);
      check("retx", o_retx, int'(rx));
      tick();
      check("txcmd_one_cycle", int'(bus.sched_txcmd_p), 0);
      m_wait = 1;
    end else begin
      check("unused_slot_idle", int'(bus.sched_busy), 0);
    end
  endtask

  task automatic rx_event(input bit match, input logic [2:0] addr, input logic [7:0] arqn,
                          input logic [7:0] flow);
    bit ed, ef;
    int a;
    ed = 0; ef = 0;
    a = (m_wait && match) ? m_lt : int'(addr);
    bus.rx_done_p   = 1'b1;
    bus.dec_lt_addr = 3'(a);
    bus.dec_arqn    = arqn;
    bus.dec_flow    = flow;
    m_flow[a] = flow[a];
    if (m_wait && match) begin
      m_poll[a] = 0;
      m_resp(0, arqn[a], ed, ef);
      m_wait = 0;
    end
    tick();
    bus.rx_done_p = 1'b0;
    o_done  = int'(bus.txdata_done_p);
    o_flush = int'(bus.sched_flush_p);
    check("rx_done", o_done, int'(ed));
    check("rx_flush", o_flush, int'(ef));
    check("rx_busy", int'(bus.sched_busy), int'(m_wait));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_txcmd"}, int'(bus.sched_txcmd_p), 0);
    check({tag, "_lt"}, int'(bus.sched_lt_addr), 0);
    check({tag, "_pktype"}, int'(bus.sched_pktype), 0);
    check({tag, "_retx"}, int'(bus.sched_retx), 0);
    check({tag, "_done"}, int'(bus.txdata_done_p), 0);
    check({tag, "_flush"}, int'(bus.sched_flush_p), 0);
    check({tag, "_busy"}, int'(bus.sched_busy), 0);
  endtask

  initial begin
    int exp_rr [4] = '{1, 2, 3, 1};
    rst = 1'b1;
    bus.regi_isMaster = 1'b1;
    bus.ms_tslot_p = 1'b0;
    bus.rx_done_p = 1'b0;
    bus.dec_lt_addr = 3'd0;
    bus.dec_arqn = 8'h00;
    bus.dec_flow = 8'hff;
    m_reset();
    set_cfg(8'h0e, 8'h0e, 0, 0, 4'h4);
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // round-robin, all ACK
    for (int s = 0; s < 4; s++) begin
      slot(0, 8'hff, 8'hff);
      check("rr_lt", o_lt, exp_rr[s]);
      check("rr_pktype", o_pt, 4);
      rx_event(1, 3'd0, 8'hff, 8'hff);
      check("rr_done", o_done, 1);
    end

    // retry then flush at max_retry=3
    set_cfg(8'h04, 8'h04, 0, 3, 4'h9);
    for (int s = 0; s < 3; s++) begin
      slot(0, 8'hff, 8'hff);
      check("fl_lt", o_lt, 2);
      check("fl_retx", o_retx, (s != 0) ? 1 : 0);
      rx_event(1, 3'd0, 8'h00, 8'hff);
      check("fl_flush", o_flush, (s == 2) ? 1 : 0);
      check("fl_done", o_done, (s == 2) ? 1 : 0);
    end

    // flow stop then poll after tpoll slots
    set_cfg(8'h02, 8'h02, 4, 0, 4'h9);
    slot(0, 8'hff, 8'hff);
    check("fs_first_pktype", o_pt, 9);
    rx_event(1, 3'd0, 8'hff, 8'h00);
    for (int s = 0; s < 4; s++) begin
      slot(0, 8'hff, 8'hff);
      check("fs_cmd", o_hit, (s == 3) ? 1 : 0);
    end
    check("fs_poll_type", o_pt, 1);
    check("fs_poll_lt", o_lt, 1);
    rx_event(1, 3'd0, 8'hff, 8'hff);
    check("fs_poll_no_done", o_done, 0);
    slot(0, 8'hff, 8'hff);
    check("fs_resume_pktype", o_pt, 9);
    rx_event(1, 3'd0, 8'hff, 8'hff);

    // missing response on LT 3
    set_cfg(8'h08, 8'h08, 0, 0, 4'h5);
    slot(0, 8'hff, 8'hff);
    check("mr_lt", o_lt, 3);
    slot(0, 8'hff, 8'hff);
    check("mr_retry_lt", o_lt, 3);
    check("mr_retry_retx", o_retx, 1);
    rx_event(1, 3'd0, 8'hff, 8'hff);

    // simultaneous ACK + slot, then disable, then reset mid-WAIT
    set_cfg(8'h0e, 8'h0e, 0, 0, 4'h5);
    slot(0, 8'hff, 8'hff);
    check("sim_first_lt", o_lt, 1);
    slot(1, 8'hff, 8'hff);
    check("sim_done", o_done, 1);
    check("sim_next_lt", o_lt, 2);
    bus.regi_isMaster = 1'b0;
    tick();
    check("dis_busy", int'(bus.sched_busy), 0);
    bus.ms_tslot_p = 1'b1;
    tick();
    bus.ms_tslot_p = 1'b0;
    tick();
    check("dis_txcmd", int'(bus.sched_txcmd_p), 0);
    check("dis_done", int'(bus.txdata_done_p), 0);
    check("dis_flush", int'(bus.sched_flush_p), 0);
    m_wait = 0;
    bus.regi_isMaster = 1'b1;
    tick();
    slot(0, 8'hff, 8'hff);
    rst = 1'b1;
    tick();
    check_all_zero("rst_wait");
    rst = 1'b0;
    m_reset();
    slot(0, 8'hff, 8'hff);
    check("post_rst_lt", o_lt, 1);
    rx_event(1, 3'd0, 8'hff, 8'hff);

    // randomized slots
    for (int it = 0; it < 400; it++) begin
      int r;
      if ($urandom_range(0, 7) == 0)
        set_cfg(8'($urandom), 8'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                4'($urandom));
      r = int'($urandom_range(0, 9));
      if (m_wait) begin
        if (r < 4) rx_event(1, 3'd0, 8'($urandom), 8'($urandom | $urandom));
        else if (r == 4)
          rx_event(0, 3'((m_lt + 1 + int'($urandom_range(0, 6))) % 8), 8'($urandom),
                   8'($urandom | $urandom));
        slot(r >= 7, 8'($urandom), 8'($urandom | $urandom));
      end else begin
        if (r < 2) rx_event(0, 3'($urandom), 8'($urandom), 8'($urandom | $urandom));
        slot(0, 8'($urandom), 8'($urandom | $urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
